// File: rtl/hazard_unit_param.sv
// Decode-stage hazard, bypass and stall unit: DEPTH-stage tag pipeline plus a multdiv scoreboard.
// Optional HAZARD_STATS_EN adds saturating stall / scoreboard-wait cycle counters.

module hazard_port_lookup #(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_RDY = 2,
    parameter int SEL_W    = 2
) (
    input  logic [REG_W-1:0]            addr,
    input  logic                        used,
    input  logic [DEPTH:1][REG_W-1:0]   stg_addr,
    input  logic [DEPTH:1]              stg_vld,
    input  logic [DEPTH:1]              stg_load,
    input  logic                        md_busy,
    input  logic                        md_ready,
    input  logic [REG_W-1:0]            md_tag,
    output logic [SEL_W-1:0]            sel,
    output logic                        haz_ld,
    output logic                        haz_md
);
    logic hit;

    always_comb begin
        sel    = '0;
        haz_ld = 1'b0;
        haz_md = 1'b0;
        hit    = 1'b0;
        if (used && addr != '0) begin
            // Scan oldest to youngest so the youngest matching stage decides.
            for (int k = DEPTH; k >= 1; k--) begin
                if (stg_vld[k] && stg_addr[k] == addr) begin
                    hit = 1'b1;
                    if (stg_load[k] && k < LOAD_RDY) begin
                        haz_ld = 1'b1;
                        sel    = '0;
                    end else begin
                        haz_ld = 1'b0;
                        sel    = SEL_W'(k);
                    end
                end
            end
            if (!hit && md_busy && md_tag == addr) begin
                if (md_ready) sel = SEL_W'(DEPTH + 1);
                else          haz_md = 1'b1;
            end
        end
    end
endmodule

module hazard_unit_param #(
    parameter int REG_W    = 5,
    parameter int NUM_READ = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_RDY = 2,
    localparam int SEL_W   = $clog2(DEPTH + 2)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_READ*REG_W-1:0]   rd_addr,
    input  logic [NUM_READ-1:0]         rd_used,
    input  logic [REG_W-1:0]            wr_addr,
    input  logic                        wr_en,
    input  logic [1:0]                  wr_class,
    input  logic                        md_ready,
    output logic                        md_start,
    output logic                        stall,
    output logic                        md_busy,
    output logic [NUM_READ*SEL_W-1:0]   fwd_sel
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 md_wait_cycles
`endif
);
    typedef struct packed {
        logic [REG_W-1:0] addr;
        logic             load;
    } tag_t;

    tag_t [DEPTH:1]                 stg;
    logic [DEPTH:1]                 vld_pipe;
    logic [DEPTH:1][REG_W-1:0]      stg_addr;
    logic [DEPTH:1]                 stg_load;
    logic [REG_W-1:0]               md_tag;
    logic [NUM_READ-1:0][SEL_W-1:0] sel_c;
    logic [NUM_READ-1:0]            haz_ld, haz_md;
    logic                           is_md, is_load, md_struct, dec_vld;

    assign is_md     = (wr_class == 2'b10);
    assign is_load   = wr_class[0];
    assign md_struct = wr_en & is_md & md_busy & ~md_ready;
    assign stall     = (|haz_ld) | (|haz_md) | md_struct;
    assign md_start  = wr_en & is_md & ~stall;
    // Multdiv ops live only in the scoreboard, never in the tag pipeline.
    assign dec_vld   = wr_en & ~stall & ~is_md & (wr_addr != '0);

    always_comb begin
        for (int k = 1; k <= DEPTH; k++) begin
            stg_addr[k] = stg[k].addr;
            stg_load[k] = stg[k].load;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        hazard_port_lookup #(
            .REG_W(REG_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .SEL_W(SEL_W)
        ) u_lookup (
            .addr     (rd_addr[i*REG_W +: REG_W]),
            .used     (rd_used[i]),
            .stg_addr (stg_addr),
            .stg_vld  (vld_pipe),
            .stg_load (stg_load),
            .md_busy  (md_busy),
            .md_ready (md_ready),
            .md_tag   (md_tag),
            .sel      (sel_c[i]),
            .haz_ld   (haz_ld[i]),
            .haz_md   (haz_md[i])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stg      <= '0;
            vld_pipe <= '0;
            fwd_sel  <= '0;
            md_busy  <= 1'b0;
            md_tag   <= '0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                stg[k]      <= stg[k-1];
                vld_pipe[k] <= vld_pipe[k-1];
            end
            stg[1]      <= '{addr: wr_addr, load: is_load};
            vld_pipe[1] <= dec_vld;
            fwd_sel     <= stall ? '0 : sel_c;
            // A new issue takes precedence over a retiring result in the same cycle.
            if (md_start && wr_addr != '0) begin
                md_busy <= 1'b1;
                md_tag  <= wr_addr;
            end else if (md_ready) begin
                md_busy <= 1'b0;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles   <= '0;
            md_wait_cycles <= '0;
        end else begin
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (stall && !(|haz_ld) && md_wait_cycles != '1)
                md_wait_cycles <= md_wait_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_unit_param.sv
// Directed bench for hazard_unit_param: default 2-port/2-stage build plus a 3-port/4-stage build.
module tb_hazard_unit_param;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_used;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic [1:0]  wr_class;
    logic        md_ready;
    logic        md_start, stall, md_busy;
    logic [3:0]  fwd_sel;

    logic [14:0] rd_addr4 = '0;
    logic [2:0]  rd_used4 = '0;
    logic [4:0]  wr_addr4 = '0;
    logic        wr_en4 = 1'b0;
    logic [1:0]  wr_class4 = '0;
    logic        md_ready4 = 1'b0;
    logic        md_start4, stall4, md_busy4;
    logic [8:0]  fwd_sel4;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, md_wait_cycles, stall_cycles4, md_wait_cycles4;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int exp_cnt = 0;
    bit exp_st = 0;

    always #5 clock = ~clock;

    hazard_unit_param dut (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_used(rd_used),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_class(wr_class), .md_ready(md_ready),
        .md_start(md_start), .stall(stall), .md_busy(md_busy), .fwd_sel(fwd_sel)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles), .md_wait_cycles(md_wait_cycles)
`endif
    );

    hazard_unit_param #(.NUM_READ(3), .DEPTH(4), .LOAD_RDY(2)) dut4 (
        .clock(clock), .reset(reset), .rd_addr(rd_addr4), .rd_used(rd_used4),
        .wr_addr(wr_addr4), .wr_en(wr_en4), .wr_class(wr_class4), .md_ready(md_ready4),
        .md_start(md_start4), .stall(stall4), .md_busy(md_busy4), .fwd_sel(fwd_sel4)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles4), .md_wait_cycles(md_wait_cycles4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used,
                         input logic [4:0] wa, input logic we, input logic [1:0] cls,
                         input logic mdr);
        rd_addr  = {a1, a0};
        rd_used  = used;
        wr_addr  = wa;
        wr_en    = we;
        wr_class = cls;
        md_ready = mdr;
        exp_st   = 0;
        #1;
    endtask

    task automatic drive4(input logic [14:0] ra, input logic [2:0] used, input logic [4:0] wa,
                          input logic we, input logic [1:0] cls);
        rd_addr4  = ra;
        rd_used4  = used;
        wr_addr4  = wa;
        wr_en4    = we;
        wr_class4 = cls;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic chk_stall(input string tag, input bit e);
        check(tag, 32'(stall), 32'(e));
        exp_st = e;
    endtask

    task automatic tick();
        if (exp_st) exp_cnt++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_busy", 32'(md_busy), 0);
        check("rst_sel", 32'(fwd_sel), 0);
        check("rst_mdstart", 32'(md_start), 0);

        // ALU producer, immediate and one-later consumers
        drive(5'd0, 5'd0, 2'd0, 5'd3, 1'b1, 2'd0, 1'b0); chk_stall("alu_w", 0); tick();
        drive(5'd3, 5'd0, 2'd1, 5'd4, 1'b1, 2'd0, 1'b0); chk_stall("raw_alu", 0); tick();
        check("sel_s1", 32'(fwd_sel), 1);
        drive(5'd0, 5'd3, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0); chk_stall("raw_s2", 0); tick();
        check("sel_s2", 32'(fwd_sel), 8);
        idle(); tick(); tick();

        // load-use: one stall, bubble, then stage-2 forward
        drive(5'd0, 5'd0, 2'd0, 5'd5, 1'b1, 2'd1, 1'b0); tick();
        drive(5'd5, 5'd0, 2'd1, 5'd6, 1'b1, 2'd0, 1'b0); chk_stall("ld_use", 1);
        check("ld_use_mds", 32'(md_start), 0); tick();
        check("ld_bub_sel", 32'(fwd_sel), 0);
        drive(5'd5, 5'd6, 2'd3, 5'd6, 1'b1, 2'd0, 1'b0); chk_stall("ld_use2", 0); tick();
        check("ld_fwd", 32'(fwd_sel), 2);
        idle(); tick(); tick();
        drive(5'd0, 5'd0, 2'd0, 5'd5, 1'b1, 2'd3, 1'b0); tick();
        drive(5'd0, 5'd5, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0); chk_stall("ld3_use", 1); tick();
        drive(5'd0, 5'd5, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0); chk_stall("ld3_use2", 0); tick();
        check("ld3_fwd", 32'(fwd_sel), 8);
        idle(); tick(); tick();

        // multdiv scoreboard: independent ops flow, reader waits for md_ready
        drive(5'd0, 5'd0, 2'd0, 5'd7, 1'b1, 2'd2, 1'b0); chk_stall("md_iss", 0);
        check("md_start", 32'(md_start), 1); tick();
        check("md_busy1", 32'(md_busy), 1);
        for (int i = 0; i < 3; i++) begin
            drive(5'd1, 5'd2, 2'd3, 5'(10 + i), 1'b1, 2'd0, 1'b0); chk_stall("md_indep", 0); tick();
        end
        drive(5'd0, 5'd7, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0); chk_stall("md_rd", 1); tick();
        check("md_rd_sel0", 32'(fwd_sel), 0);
        drive(5'd0, 5'd7, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0); chk_stall("md_rd2", 1); tick();
        drive(5'd0, 5'd7, 2'd2, 5'd0, 1'b0, 2'd0, 1'b1); chk_stall("md_rdy", 0); tick();
        check("md_sel", 32'(fwd_sel), 12);
        check("md_busy0", 32'(md_busy), 0);
        idle(); tick(); tick();

        // multdiv while busy, then same-cycle retire/issue swaps the tag
        drive(5'd0, 5'd0, 2'd0, 5'd8, 1'b1, 2'd2, 1'b0); check("md8_start", 32'(md_start), 1); tick();
        drive(5'd0, 5'd0, 2'd0, 5'd9, 1'b1, 2'd2, 1'b0); chk_stall("md_struct", 1);
        check("md_struct_st", 32'(md_start), 0); tick();
        check("md_struct_busy", 32'(md_busy), 1);
        drive(5'd0, 5'd0, 2'd0, 5'd9, 1'b1, 2'd2, 1'b1); chk_stall("md_swap", 0);
        check("md_swap_st", 32'(md_start), 1); tick();
        check("md_swap_busy", 32'(md_busy), 1);
        drive(5'd0, 5'd9, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0); chk_stall("md_newtag", 1); tick();
        drive(5'd8, 5'd0, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0); chk_stall("md_oldtag", 0); tick();
        check("md_oldtag_sel", 32'(fwd_sel), 0);
        drive(5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1); tick();
        check("md_clr", 32'(md_busy), 0);

        // younger ALU writer of md_tag wins for readers
        drive(5'd0, 5'd0, 2'd0, 5'd14, 1'b1, 2'd2, 1'b0); tick();
        drive(5'd0, 5'd0, 2'd0, 5'd14, 1'b1, 2'd0, 1'b0); tick();
        drive(5'd14, 5'd0, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0); chk_stall("waw", 0); tick();
        check("waw_sel", 32'(fwd_sel), 1);
        drive(5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1); tick();
        idle(); tick(); tick();

        // r0 never hazards, multdiv to r0 leaves the scoreboard idle
        drive(5'd0, 5'd0, 2'd0, 5'd0, 1'b1, 2'd1, 1'b0); tick();
        drive(5'd0, 5'd0, 2'd0, 5'd0, 1'b1, 2'd0, 1'b0); tick();
        drive(5'd0, 5'd0, 2'd3, 5'd0, 1'b1, 2'd1, 1'b0); chk_stall("r0", 0); tick();
        check("r0_sel", 32'(fwd_sel), 0);
        drive(5'd0, 5'd0, 2'd0, 5'd0, 1'b1, 2'd2, 1'b0); check("md_r0_start", 32'(md_start), 1); tick();
        check("md_r0_busy", 32'(md_busy), 0);
        idle(); tick();
`ifdef HAZARD_STATS_EN
        check("stall_cnt", stall_cycles, 32'(exp_cnt));
`endif

        // asynchronous reset with a multdiv in flight
        drive(5'd0, 5'd0, 2'd0, 5'd13, 1'b1, 2'd2, 1'b0); tick();
        check("rst_md_busy1", 32'(md_busy), 1);
        reset = 1'b1;
        #1;
        check("rst_async_busy", 32'(md_busy), 0);
        exp_cnt = 0;
        idle();
        reset = 1'b0;
        drive(5'd13, 5'd0, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1); chk_stall("rst_rd", 0); tick();
        check("rst_rdy_ign", 32'(md_busy), 0);
        check("rst_rd_sel", 32'(fwd_sel), 0);
        idle(); tick();

        // 3-port / 4-stage build: r9 in stages 2 and 4, youngest wins
        drive4(15'd0, 3'd0, 5'd9, 1'b1, 2'd0); tick();
        drive4(15'd0, 3'd0, 5'd20, 1'b1, 2'd0); tick();
        drive4(15'd0, 3'd0, 5'd9, 1'b1, 2'd0); tick();
        drive4(15'd0, 3'd0, 5'd0, 1'b0, 2'd0); tick();
        drive4({5'd9, 10'd0}, 3'b100, 5'd0, 1'b0, 2'd0);
        check("d4_stall", 32'(stall4), 0); tick();
        check("d4_sel", 32'(fwd_sel4), 128);
        drive4(15'd0, 3'd0, 5'd21, 1'b1, 2'd1); tick();
        drive4({10'd0, 5'd21}, 3'b001, 5'd0, 1'b0, 2'd0);
        check("d4_ld_use", 32'(stall4), 1); tick();
        drive4({10'd0, 5'd21}, 3'b001, 5'd0, 1'b0, 2'd0);
        check("d4_ld_use2", 32'(stall4), 0); tick();
        check("d4_ld_sel", 32'(fwd_sel4), 2);
        drive4(15'd0, 3'd0, 5'd0, 1'b0, 2'd0); tick();
`ifdef HAZARD_STATS_EN
        check("stall_cnt_rst", stall_cycles, 32'(exp_cnt));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
